// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch stage with an IF/ID register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 hazard hold; freezes IF/ID and PC advance
//   branch_taken          redirect request from downstream
//   branch_target[31:0]   redirect PC (bits [1:0] forced to 00)
//   imem_req/imem_addr    instruction memory request (addr is always the PC)
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     instruction response
//   if_id_pc/instr/valid  IF/ID register contents
//   opcode[6:0]           instr[6:0] of a valid entry, 0 for a bubble
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetched[31:0]    count of valid IF/ID loads
//   perf_bubbles[31:0]    count of cycles with an empty, unstalled IF/ID
//
// State table:
//   REQ  | request issued at current PC, waiting for grant
//   WAIT | granted, waiting for the response word
//   HOLD | response arrived during stall; word parked in hold buffer
//   DROP | redirected while a response is in flight; discard it
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
`endif
  output logic [6:0]  opcode
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        deliver;
  logic [31:0] del_pc;
  logic [31:0] del_instr;
  logic [31:0] target_aligned;

  assign target_aligned = {branch_target[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    deliver      = 1'b0;
    del_pc       = pc_q;
    del_instr    = imem_rdata;

    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          if (branch_taken) begin
            pc_d    = target_aligned;
            state_d = S_DROP;
          end else begin
            state_d = S_WAIT;
          end
        end else if (branch_taken) begin
          pc_d = target_aligned;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (branch_taken) begin
            pc_d    = target_aligned;
            state_d = S_REQ;
          end else if (stall) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end else begin
            deliver = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end else if (branch_taken) begin
          // Response still in flight: it must be swallowed in DROP.
          pc_d    = target_aligned;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          pc_d    = target_aligned;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver   = 1'b1;
          del_pc    = hold_pc_q;
          del_instr = hold_instr_q;
          pc_d      = pc_q + 32'd4;
          state_d   = S_REQ;
        end
      end
      S_DROP: begin
        if (branch_taken) begin
          pc_d = target_aligned;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // IF/ID: flush beats stall, stall beats delivery, otherwise a bubble.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = 1'b0;
    if (branch_taken) begin
      if_id_valid_d = 1'b0;
    end else if (stall) begin
      if_id_valid_d = if_id_valid_q;
    end else if (deliver) begin
      if_id_pc_d    = del_pc;
      if_id_instr_d = del_instr;
      if_id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      hold_pc_q     <= 32'd0;
      hold_instr_q  <= 32'd0;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= 32'd0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign opcode      = if_id_valid_q ? if_id_instr_q[6:0] : 7'b0000000;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (if_id_valid_d && !if_id_valid_q) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end else if (deliver && !branch_taken && !stall) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (!if_id_valid_q && !stall) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [6:0]  opcode;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles),
`endif
    .opcode       (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_bad;

  localparam logic [31:0] I0    = 32'h00A0_0093;
  localparam logic [31:0] I4    = 32'h0010_0133;
  localparam logic [31:0] I8    = 32'h1234_5037;
  localparam logic [31:0] IC    = 32'hABCD_E06F;
  localparam logic [31:0] I100  = 32'h0000_8067;
  localparam logic [31:0] I200  = 32'h0040_0023;
  localparam logic [31:0] IFFC  = 32'hFFF0_0003;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;
  localparam logic [31:0] JUNK2 = 32'hCAFE_F00D;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] d,
                       input logic s, input logic b, input logic [31:0] t);
    imem_gnt      = g;
    imem_rvalid   = rv;
    imem_rdata    = d;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
  endtask

  task automatic add(input logic g, input logic rv, input logic [31:0] d,
                     input logic s, input logic b, input logic [31:0] t,
                     input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.gnt = g; v.rvalid = rv; v.rdata = d; v.stall = s; v.br = b; v.tgt = t;
    v.ereq = er; v.eaddr = ea; v.evalid = ev; v.epc = ep; v.einstr = ei;
    vq.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

    //  gnt rv  rdata  stl br  tgt            | req addr          | valid pc           instr
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h0,        0, 32'd0, 32'd0);
    add(1, 1, I0,    0, 0, 32'd0,         0, 32'h0,        1, 32'h0, I0);
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h4,        0, 32'd0, 32'd0);
    add(1, 1, I4,    0, 0, 32'd0,         0, 32'h4,        1, 32'h4, I4);
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h8,        0, 32'd0, 32'd0);
    add(0, 1, I8,    0, 0, 32'd0,         0, 32'h8,        1, 32'h8, I8);
    // stall for three cycles around a response
    add(1, 0, 32'd0, 1, 0, 32'd0,         1, 32'hC,        1, 32'h8, I8);
    add(1, 1, IC,    1, 0, 32'd0,         0, 32'hC,        1, 32'h8, I8);
    add(0, 0, 32'd0, 1, 0, 32'd0,         0, 32'hC,        1, 32'h8, I8);
    add(0, 0, 32'd0, 0, 0, 32'd0,         0, 32'hC,        1, 32'hC, IC);
    // redirect in WAIT without rvalid -> DROP, late word discarded
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h10,       0, 32'd0, 32'd0);
    add(0, 0, 32'd0, 0, 1, 32'h100,       0, 32'h10,       0, 32'd0, 32'd0);
    add(0, 1, JUNK,  0, 0, 32'd0,         0, 32'h100,      0, 32'd0, 32'd0);
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h100,      0, 32'd0, 32'd0);
    add(0, 1, I100,  0, 0, 32'd0,         0, 32'h100,      1, 32'h100, I100);
    // redirect coincident with rvalid, unaligned target
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h104,      0, 32'd0, 32'd0);
    add(0, 1, JUNK,  0, 1, 32'h203,       0, 32'h104,      0, 32'd0, 32'd0);
    add(0, 0, 32'd0, 0, 0, 32'd0,         1, 32'h200,      0, 32'd0, 32'd0);
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h200,      0, 32'd0, 32'd0);
    add(0, 1, I200,  0, 0, 32'd0,         0, 32'h200,      1, 32'h200, I200);
    // redirect to top of address space, PC wraps
    add(0, 0, 32'd0, 0, 1, 32'hFFFF_FFFC, 1, 32'h204,      0, 32'd0, 32'd0);
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'hFFFF_FFFC, 0, 32'd0, 32'd0);
    add(0, 1, IFFC,  0, 0, 32'd0,         0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, IFFC);
    add(0, 0, 32'd0, 0, 0, 32'd0,         1, 32'h0,        0, 32'd0, 32'd0);
    // redirect while a stalled word sits in HOLD
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h0,        0, 32'd0, 32'd0);
    add(0, 1, JUNK2, 1, 0, 32'd0,         0, 32'h0,        0, 32'd0, 32'd0);
    add(0, 0, 32'd0, 1, 1, 32'h40,        0, 32'h0,        0, 32'd0, 32'd0);
    // grant+redirect in REQ -> DROP, second redirect inside DROP
    add(1, 0, 32'd0, 0, 1, 32'h80,        1, 32'h40,       0, 32'd0, 32'd0);
    add(0, 0, 32'd0, 0, 1, 32'h90,        0, 32'h80,       0, 32'd0, 32'd0);
    add(0, 1, JUNK,  0, 0, 32'd0,         0, 32'h90,       0, 32'd0, 32'd0);
    add(1, 0, 32'd0, 0, 0, 32'd0,         1, 32'h90,       0, 32'd0, 32'd0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_opcode", {25'd0, opcode}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].gnt, vq[i].rvalid, vq[i].rdata, vq[i].stall, vq[i].br, vq[i].tgt);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].ereq});
      chk($sformatf("v%0d_addr", i), imem_addr, vq[i].eaddr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vq[i].evalid});
      chk($sformatf("v%0d_opcode", i), {25'd0, opcode},
          vq[i].evalid ? {25'd0, vq[i].einstr[6:0]} : 32'd0);
      if (vq[i].evalid) begin
        chk($sformatf("v%0d_pc", i), if_id_pc, vq[i].epc);
        chk($sformatf("v%0d_instr", i), if_id_instr, vq[i].einstr);
      end
    end

    // reset asserted mid-WAIT (last vector left the stage in WAIT at 0x90)
    @(negedge clk);
    drive(0, 0, 32'd0, 0, 0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_addr", imem_addr, 32'h0);
    chk("midwait_rst_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 32'd0, 0, 0, 32'd0);
    @(negedge clk);
    drive(0, 1, I0, 0, 0, 32'd0);
    #1;
    chk("restart_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("restart_valid", {31'd0, if_id_valid}, 32'd1);
    chk("restart_pc", if_id_pc, 32'h0);
    chk("restart_instr", if_id_instr, I0);

    // reset while IF/ID holds a valid entry clears it at once
    @(negedge clk);
    drive(0, 0, 32'd0, 0, 0, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst2_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst2_instr", if_id_instr, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    // 2 idle bubbles, then 10 deliveries with stall covering each REQ cycle
    // after the first, so exactly 4 bubble cycles in total.
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'd0, 0, 0, 32'd0);
    @(negedge clk);
    drive(0, 0, 32'd0, 0, 0, 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1, 0, 32'd0, (k != 0), 0, 32'd0);
      @(negedge clk);
      drive(0, 1, 32'h0000_0013 + (k << 8), 0, 0, 32'd0);
    end
    @(negedge clk);
    drive(0, 0, 32'd0, 1, 0, 32'd0);
    #1;
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_bubbles", perf_bubbles, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
